// File: rtl/alu_issue_stage.sv
// Turns a MIPS instruction word plus register read data into ALU opcode/operands behind a 2-entry skid buffer.
// Optional macro ALU_ISSUE_ILLEGAL_STALL_EN: an accepted illegal instruction blocks input until flush or reset.
module alu_issue_stage #(
  parameter int         N          = 31,
  parameter logic [5:0] ILLEGAL_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [N:0]  rs_data,
  input  logic [N:0]  rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [N:0]  alu_a,
  output logic [N:0]  alu_b,
  output logic [5:0]  alu_op,
  output logic        illegal
);

  typedef struct packed {
    logic [N:0] a;
    logic [N:0] b;
    logic [5:0] op;
    logic       ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t     state_p1, state_nxt;
  entry_t     dec_p0, head_p1, skid_p1, head_nxt, skid_nxt;
  logic       trap_p1, trap_nxt, rdy_nxt, acc_in, acc_out;
  logic [5:0] opc, fn;
  logic [N:0] zimm, simm, lui_b;
  logic       unused_fields;

  function automatic entry_t mk(input logic [5:0] op, input logic [N:0] a, input logic [N:0] b);
    entry_t e;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.ill = 1'b0;
    return e;
  endfunction

  assign opc           = instr[31:26];
  assign fn            = instr[5:0];
  assign unused_fields = ^instr[25:16];

  // Stage p0: decode on the input side
  always_comb begin
    zimm         = '0;
    zimm[15:0]   = instr[15:0];
    simm         = {(N+1){instr[15]}};
    simm[15:0]   = instr[15:0];
    lui_b        = '0;
    lui_b[10:6]  = 5'd16;
    dec_p0.a     = '0;
    dec_p0.b     = '0;
    dec_p0.op    = ILLEGAL_OP;
    dec_p0.ill   = 1'b1;
    case (opc)
      6'b000000:
        case (fn)
          6'b100001, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010: dec_p0 = mk(fn, rs_data, rt_data);
          6'b000000, 6'b000010, 6'b000011: dec_p0 = mk(fn, rt_data, zimm);
          6'b000100, 6'b000110, 6'b000111: dec_p0 = mk(fn, rt_data, rs_data);
          default: ;
        endcase
      6'b001001: dec_p0 = mk(6'b100001, rs_data, simm);
      6'b001010: dec_p0 = mk(6'b101010, rs_data, simm);
      6'b001100: dec_p0 = mk(6'b100100, rs_data, zimm);
      6'b001101: dec_p0 = mk(6'b100101, rs_data, zimm);
      6'b001110: dec_p0 = mk(6'b100110, rs_data, zimm);
      // LUI is issued as SLL of the immediate by 16
      6'b001111: dec_p0 = mk(6'b000000, zimm, lui_b);
      default: ;
    endcase
  end

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  always_comb begin
    state_nxt = state_p1;
    head_nxt  = head_p1;
    skid_nxt  = skid_p1;
    trap_nxt  = trap_p1;
    rdy_nxt   = 1'b1;
    case (state_p1)
      EMPTY: if (acc_in) begin
        state_nxt = ONE;
        head_nxt  = dec_p0;
      end
      ONE: begin
        if (acc_in && !acc_out) begin
          state_nxt = TWO;
          skid_nxt  = dec_p0;
        end else if (acc_in && acc_out) begin
          head_nxt  = dec_p0;
        end else if (acc_out) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (acc_out) begin
        state_nxt = ONE;
        head_nxt  = skid_p1;
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef ALU_ISSUE_ILLEGAL_STALL_EN
    if (acc_in && dec_p0.ill) trap_nxt = 1'b1;
`endif
    if (flush) begin
      state_nxt = EMPTY;
      trap_nxt  = 1'b0;
    end
    rdy_nxt = (state_nxt != TWO) && !trap_nxt;
  end

  // Stage p1: head/skid registers drive every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      in_ready <= 1'b1;
      trap_p1  <= 1'b0;
      head_p1  <= '0;
      skid_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      in_ready <= rdy_nxt;
      trap_p1  <= trap_nxt;
      head_p1  <= head_nxt;
      skid_p1  <= skid_nxt;
    end
  end

  assign out_valid = (state_p1 != EMPTY);
  assign alu_a     = head_p1.a;
  assign alu_b     = head_p1.b;
  assign alu_op    = head_p1.op;
  assign illegal   = head_p1.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model plus directed literal cases.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0, alu_a, alu_b;
  logic [5:0]  alu_op;
  int          n_cmp = 0, n_bad = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; logic ill; } ent_t;
  ent_t        q[$];
  bit          trap = 1'b0;
  logic [31:0] seen[$];
  logic [5:0]  ops_tbl [7]  = '{6'h00, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0]  fns_tbl [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  function automatic ent_t ref_decode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    ent_t e;
    logic [5:0]  op, fn;
    logic [31:0] zimm, simm;
    op   = ins[31:26];
    fn   = ins[5:0];
    zimm = {16'h0, ins[15:0]};
    simm = {{16{ins[15]}}, ins[15:0]};
    e    = '{6'h3F, 32'h0, 32'h0, 1'b1};
    if (op == 6'h00 && fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) e = '{fn, rs, rt, 1'b0};
    else if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}) e = '{fn, rt, zimm, 1'b0};
    else if (op == 6'h00 && fn inside {6'h04, 6'h06, 6'h07}) e = '{fn, rt, rs, 1'b0};
    else if (op == 6'h09) e = '{6'h21, rs, simm, 1'b0};
    else if (op == 6'h0A) e = '{6'h2A, rs, simm, 1'b0};
    else if (op == 6'h0C) e = '{6'h24, rs, zimm, 1'b0};
    else if (op == 6'h0D) e = '{6'h25, rs, zimm, 1'b0};
    else if (op == 6'h0E) e = '{6'h26, rs, zimm, 1'b0};
    else if (op == 6'h0F) e = '{6'h00, zimm, 32'h400, 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] addu(logic [4:0] rd);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h21};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of at most two decoded entries
  initial begin : model
    bit acc_in, acc_out;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        trap = 1'b0;
      end else begin
        acc_in  = in_valid && (q.size() < 2) && !trap;
        acc_out = out_ready && (q.size() > 0);
        if (flush) begin
          q.delete();
          trap = 1'b0;
        end else begin
          if (acc_out) void'(q.pop_front());
          if (acc_in) begin
            q.push_back(ref_decode(instr, rs_data, rt_data));
`ifdef ALU_ISSUE_ILLEGAL_STALL_EN
            if (q[$].ill) trap = 1'b1;
`endif
          end
        end
      end
    end
  end

  always @(posedge clk) if (rst_n && out_valid && out_ready) seen.push_back(alu_a);

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_in_ready", 32'(in_ready), 32'((q.size() < 2) && !trap));
      if (q.size() > 0) begin
        chk("m_alu_op", 32'(alu_op), 32'(q[0].op));
        chk("m_alu_a", alu_a, q[0].a);
        chk("m_alu_b", alu_b, q[0].b);
        chk("m_illegal", 32'(illegal), 32'(q[0].ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(string nm);
    bit r, done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got no accept, expected accept within 20 cycles", nm);
    end
  endtask

  task automatic push(string nm, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    wait_accept(nm);
  endtask

  task automatic one(string nm, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                     logic [5:0] eop, logic [31:0] ea, logic [31:0] eb, logic eill);
    out_ready = 1'b1;
    push(nm, ins, rs, rt);
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_op"}, 32'(alu_op), 32'(eop));
    chk({nm, "_a"}, alu_a, ea);
    chk({nm, "_b"}, alu_b, eb);
    chk({nm, "_ill"}, 32'(illegal), 32'(eill));
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          kind;
    r    = $urandom;
    kind = $urandom_range(0, 19);
    if (kind == 0) return r;
    r[31:26] = ops_tbl[$urandom_range(0, 6)];
    if (r[31:26] == 6'h00 && kind != 1) r[5:0] = fns_tbl[$urandom_range(0, 12)];
    return r;
  endfunction

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    one("addu",  32'h00221821, 5, 7, 6'h21, 5, 7, 1'b0);
    one("addiu", {6'h09, 5'd1, 5'd2, 16'hFFFF}, 3, 9, 6'h21, 3, 32'hFFFF_FFFF, 1'b0);
    one("ori",   {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 3, 9, 6'h25, 3, 32'h0000_FFFF, 1'b0);
    one("sra",   {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 1, 32'h8000_0000,
                 6'h03, 32'h8000_0000, 32'h0000_1903, 1'b0);
    one("lui",   {6'h0F, 5'd0, 5'd1, 16'h1234}, 9, 9, 6'h00, 32'h1234, 32'h400, 1'b0);
    one("srav",  {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 3, 32'hF0, 6'h07, 32'hF0, 3, 1'b0);

    // backpressure: two entries fill the buffer, the third waits
    out_ready = 1'b0;
    push("bp0", addu(5'd3), 11, 0);
    push("bp1", addu(5'd3), 22, 0);
    instr = addu(5'd3); rs_data = 33; rt_data = 0; in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_head_a", alu_a, 11);
    end
    seen.delete();
    out_ready = 1'b1;
    wait_accept("bp2");
    repeat (4) step();
    chk("bp_count", 32'(seen.size()), 3);
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 11);
      chk("bp_order1", seen[1], 22);
      chk("bp_order2", seen[2], 33);
    end

    one("illegal", 32'hFC00_0000, 5, 7, 6'h3F, 0, 0, 1'b1);
`ifdef ALU_ISSUE_ILLEGAL_STALL_EN
    repeat (2) begin
      chk("trap_in_ready", 32'(in_ready), 0);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("trap_flush_valid", 32'(out_valid), 0);
    chk("trap_flush_ready", 32'(in_ready), 1);
`else
    chk("illegal_in_ready", 32'(in_ready), 1);
`endif

    // flush together with an input: buffered and incoming entries are both dropped
    out_ready = 1'b0;
    push("fl0", addu(5'd3), 44, 0);
    instr = addu(5'd3); rs_data = 55; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    step();
    chk("flush_valid2", 32'(out_valid), 0);

    // asynchronous reset while the buffer is full
    push("rs0", addu(5'd3), 66, 1);
    push("rs1", addu(5'd3), 77, 1);
    chk("two_in_ready", 32'(in_ready), 0);
    chk("two_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_alu_op", 32'(alu_op), 0);
    chk("arst_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      instr     = rand_instr();
      rs_data   = $urandom;
      rt_data   = $urandom;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end
endmodule
